// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave core.
package spi_pkg;

    // Controller states: deselected, holding-register transfer, bit shifting.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Flip-flops per input synchroniser chain.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchroniser for asynchronous pad inputs.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the pad value through the chain; reset to the line's idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled SPI slave: configurable width, mode and bit order.
//
// Transmit handshake: tx_data is captured on any clk edge where tx_valid and
// tx_ready are both high; tx_ready is high exactly when the holding register
// is empty, and tx_valid may be raised in any state. Receive side has no back
// pressure: rx_valid/done pulse for one cycle as rx_data is updated.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ss,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             underrun,
    output spi_state_e       state_dbg
);

    localparam int         CW            = $clog2(WIDTH + 1);
    localparam logic [1:0] MODE          = {CPOL != 0, CPHA != 0};
    localparam logic       SCK_IDLE_HIGH = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
    localparam logic       SAMPLE_LEAD   = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rx_ins(input logic [WIDTH-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    logic ss_s, sck_s, mosi_s;
    logic ss_q, sck_q;

    spi_sync #(.RESET_VAL(1'b1))          u_sync_ss   (.clk(clk), .reset_n(reset_n), .d(ss),   .q(ss_s));
    spi_sync #(.RESET_VAL(SCK_IDLE_HIGH)) u_sync_sck  (.clk(clk), .reset_n(reset_n), .d(sck),  .q(sck_s));
    spi_sync #(.RESET_VAL(1'b0))          u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));

    // Delayed copies of synchronised ss/sck for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_q  <= 1'b1;
            sck_q <= SCK_IDLE_HIGH;
        end else begin
            ss_q  <= ss_s;
            sck_q <= sck_s;
        end
    end

    logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
    assign sck_rise    = sck_s & ~sck_q;
    assign sck_fall    = ~sck_s & sck_q;
    assign lead_edge   = SCK_IDLE_HIGH ? sck_fall : sck_rise;
    assign trail_edge  = SCK_IDLE_HIGH ? sck_rise : sck_fall;
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
    assign ss_fall     = ss_q & ~ss_s;

    spi_state_e       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] tx_sr, rx_sr, rx_next;
    logic [WIDTH-1:0] hold_data, load_word;
    logic             hold_full, load_take;

    assign rx_next   = rx_ins(rx_sr, mosi_s);
    assign load_word = hold_full ? hold_data : '0;
    assign load_take = (state == ST_LOAD) && !ss_s && hold_full;
    assign tx_ready  = ~hold_full;
    assign state_dbg = state;

    // Transmit holding register; LOAD drains it, a handshake fills it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else begin
            if (load_take) begin
                hold_full <= 1'b0;
            end
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Frame controller: select tracking, word load, bit sampling and MISO drive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            if (ss_s) begin
                // Deselect wins over any coincident sample edge.
                state   <= ST_IDLE;
                bit_cnt <= '0;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ss_fall) begin
                            state   <= ST_LOAD;
                            miso_oe <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state    <= ST_SHIFT;
                        miso_oe  <= 1'b1;
                        underrun <= ~hold_full;
                        if (SAMPLE_LEAD) begin
                            // First bit must be on the line before the first leading edge.
                            miso  <= out_bit(load_word);
                            tx_sr <= tx_adv(load_word);
                        end else begin
                            tx_sr <= load_word;
                        end
                    end
                    ST_SHIFT: begin
                        if (sample_edge) begin
                            rx_sr <= rx_next;
                            if (bit_cnt == CW'(WIDTH - 1)) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                done     <= 1'b1;
                                bit_cnt  <= '0;
                                state    <= ST_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        // In sample-on-leading modes the trailing edge after the
                        // last sample belongs to the finished word; skip it.
                        if (shift_edge && (!SAMPLE_LEAD || (bit_cnt != '0))) begin
                            miso  <= out_bit(tx_sr);
                            tx_sr <= tx_adv(tx_sr);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Parametrised SPI slave sitting behind the user-project wrapper. It is the successor to the fixed 8-bit, mode-0 slave in `top_tukka2`. It oversamples the pad-level `sck`/`ss`/`mosi` in a single system clock domain and supports configurable word width, all four SPI modes and bit order. It exchanges words with core logic over a valid/ready transmit holding register and a one-cycle receive strobe.

## Interface
Parameters:
- `WIDTH`, 8: bits per SPI word, 4..32.
- `CPOL`, 0: `sck` idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `MSB_FIRST`, 1: 1 = MSB shifted first; 0 = LSB first.

Ports:
- `clk`, in, 1: system clock. Must be ≥ 8× the `sck` frequency.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ss`, in, 1: slave select, active low, asynchronous to `clk`.
- `sck`, in, 1: SPI clock, asynchronous to `clk`.
- `mosi`, in, 1: master data in, asynchronous to `clk`.
- `miso`, out, 1: slave data out.
- `miso_oe`, out, 1: high while selected. The wrapper drives `io_oeb` = ~`miso_oe`.
- `tx_data`, in, WIDTH: next word to transmit.
- `tx_valid`, in, 1: `tx_data` offered.
- `tx_ready`, out, 1: holding register empty.
- `rx_data`, out, WIDTH: last complete received word. Held until the next word completes.
- `rx_valid`, out, 1: one-cycle strobe; `rx_data` updated this cycle.
- `done`, out, 1: one-cycle strobe at end of each word, coincident with `rx_valid`.
- `underrun`, out, 1: one-cycle strobe; a word was loaded while the holding register was empty.

## Operation
- **Synchronisers:** `ss`, `sck` and `mosi` each pass through a 2-FF synchroniser. Edges are detected on synchronised `sck` against a registered copy.
- **Edge definitions:** leading edge = transition away from `CPOL`; trailing edge = transition back to `CPOL`. The sample edge is the leading edge when `CPHA`=0, else the trailing edge. The shift edge is the opposite edge.
- **States:**
  - IDLE: `ss` high.
  - LOAD: one cycle. Moves the holding register into the shift register.
  - SHIFT: counts samples.
- **Transitions:**
  - IDLE→LOAD on synchronised `ss` falling.
  - LOAD→SHIFT unconditionally.
  - SHIFT→LOAD when the bit counter reaches WIDTH, while `ss` stays low.
  - Any state→IDLE when synchronised `ss` is high.
- **LOAD:**
  - If the holding register is full, its word is copied into the shift register and the holding register is emptied.
  - If it is empty, the shift register is loaded with all zeros and `underrun` pulses.
  - There is no bypass. A `tx_valid` accepted in the same cycle is kept for the next word.
- **Transmit holding register:** `tx_ready` = holding register empty. A handshake (`tx_valid` & `tx_ready`) captures `tx_data`. It can be written in any state, including IDLE.
- **Sample edge:** the synchronised `mosi` is shifted in and the bit counter increments, with a width of clog2(WIDTH+1).
- **MISO timing:**
  - `CPHA`=0: the first bit is driven from LOAD onward, and the shift register advances on each shift edge.
  - `CPHA`=1: the shift register advances on each leading edge, with the first bit presented on the first leading edge.
- **Bit order:** `MSB_FIRST` selects which end is driven to `miso` and which end receives `mosi`.
- **Word completion:** when the counter reaches WIDTH, the received word is copied to `rx_data`, `rx_valid`/`done` pulse for one cycle and the counter clears.
- **Abort:** `ss` rising mid-word discards the partial receive word. There is no `rx_valid`/`done`, the counter clears, and the unsent transmit bits are dropped. The holding register is not touched.
- **Deselected:** `miso`=0 and `miso_oe`=0 whenever synchronised `ss` is high.

## Timing
- **Reset values:**
  - `miso`, `miso_oe`, `rx_data`, `rx_valid`, `done`, `underrun`: 0.
  - `tx_ready`: 1.
  - State: IDLE; counter: 0.
- **Input latency:** a pin edge is visible internally 3 `clk` cycles later (2 synchroniser stages + edge register).
- **Receive latency:** `rx_valid` asserts 3–4 `clk` cycles after the final sample edge at the pin.
- **MISO settling:** `miso` changes ≤4 `clk` cycles after a shift edge. This requires `sck` half-period ≥ 4 `clk` cycles.
- **Transmit turnaround:** back-to-back words need no gap. LOAD occupies one `clk` cycle, well inside the half-period following the last sample.
- **Simultaneous events:** when a sample edge and `ss` rising land in the same cycle, the deselect wins and the word is discarded.

## Structure
- Package `spi_pkg` holds:
  - the state enum (IDLE/LOAD/SHIFT);
  - the mode localparams (`SPI_MODE0`..`SPI_MODE3` as {CPOL,CPHA});
  - the `SYNC_STAGES`=2 constant.
- Sub-module `spi_sync`: a single-bit 2-FF synchroniser with async active-low reset, instantiated three times.

## Test plan
- **Mode 0, WIDTH=8, MSB first:** preload tx 0x3C, master sends 0xA5 → `rx_data`=0xA5 with one `rx_valid`/`done` pulse; master captures 0x3C.
- **Mode 3 (CPOL=1, CPHA=1):** preload tx 0x81, master sends 0x5A → `rx_data`=0x5A; master captures 0x81; `miso_oe` falls after `ss` rises.
- **Underrun:** no tx preload, master sends 0xFF → `underrun` pulses once at LOAD; master captures 0x00; `rx_data`=0xFF.
- **Abort:** `ss` rises after 5 of 8 bits → no `rx_valid`; `rx_data` keeps its old value; `tx_ready` unchanged. The next full frame with 0x12 → `rx_data`=0x12.
- **Back-to-back, WIDTH=16, LSB first, mode 1:**
  - Setup: tx 0xBEEF preloaded, then 0xCAFE accepted during word one.
  - Stimulus: master sends 0x1234 then 0xABCD with `ss` held low throughout.
  - Response: two `rx_valid` pulses (0x1234, 0xABCD); master captures 0xBEEF, 0xCAFE.
- **Reset mid-word:** assert `reset_n` low after 3 bits → all outputs at reset values immediately. After release, a full frame completes normally.
